// File: rtl/shared_counter_arb_if.sv
// rtl/shared_counter_arb_if.sv - requester/counter bus bundle for shared_counter_arb
//
// Purpose: groups the per-port request bus and the registered status
// returned by the shared counter.
//   req      NPORTS        per-port request
//   op       2*NPORTS      per-port opcode, port i at op[2i+1:2i]
//   wrdata   WIDTH*NPORTS  per-port load data, port i at wrdata[WIDTH*i +: WIDTH]
//   value    WIDTH         current counter value
//   grant    NPORTS        one-hot, port whose op was applied at the last edge
//   wrapped  1             last applied inc/dec crossed (or clamped at) a boundary
//   conflict 1             more than one request was seen at the last edge
//   is_zero  1             value == 0
// The master modport is the requester side; the slave modport is the counter.
interface shared_counter_arb_if #(
    parameter int WIDTH  = 9,
    parameter int NPORTS = 2
);
    logic [NPORTS-1:0]       req;
    logic [2*NPORTS-1:0]     op;
    logic [WIDTH*NPORTS-1:0] wrdata;
    logic [WIDTH-1:0]        value;
    logic [NPORTS-1:0]       grant;
    logic                    wrapped;
    logic                    conflict;
    logic                    is_zero;

    modport master (
        output req, op, wrdata,
        input  value, grant, wrapped, conflict, is_zero
    );

    modport slave (
        input  req, op, wrdata,
        output value, grant, wrapped, conflict, is_zero
    );
endinterface

// File: rtl/shared_counter_arb.sv
// rtl/shared_counter_arb.sv - multi-port shared counter with internal arbiter
//
// Purpose: NPORTS requesters share one WIDTH-bit counter. Each edge with at
// least one request picks a single winner (fixed priority or round-robin)
// and applies that port's load/inc/dec/clear. Losers are not queued; they
// simply keep req high until their grant bit shows up.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active high
//   bus   shared_counter_arb_if.slave (req/op/wrdata in; value/grant/
//         wrapped/conflict/is_zero out)
// value, grant, wrapped and conflict are registers; is_zero decodes value.
module shared_counter_arb #(
    parameter int WIDTH    = 9,
    parameter int NPORTS   = 2,
    parameter int ARB_MODE = 0,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    shared_counter_arb_if.slave  bus
);

    localparam int IDXW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_DEC   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0]  value_q,    value_d;
    logic [NPORTS-1:0] grant_q,    grant_d;
    logic              wrapped_q,  wrapped_d;
    logic              conflict_q, conflict_d;
    logic [IDXW-1:0]   ptr_q,      ptr_d;

    // Arbiter results
    logic              win_valid;
    logic [IDXW-1:0]   win_idx;
    logic [IDXW-1:0]   scan_start;
    logic [IDXW:0]     scan_sum;
    logic [IDXW-1:0]   scan_idx;

    // Winner's operation and the WIDTH+1 bit inc/dec results; the extra bit
    // is only the carry/borrow that flags a boundary crossing.
    logic [1:0]        win_op;
    logic [WIDTH-1:0]  win_data;
    logic [WIDTH:0]    inc_full;
    logic [WIDTH:0]    dec_full;

    // ------------------------------------------------------------------
    // Arbiter: scan ports starting at scan_start, wrapping modulo NPORTS.
    // Fixed priority always starts at port 0; round-robin starts at the
    // pointer, which names the port that currently has top priority.
    // ------------------------------------------------------------------
    always_comb begin
        win_valid  = 1'b0;
        win_idx    = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        scan_start = (ARB_MODE != 0) ? ptr_q : '0;
        for (int k = 0; k < NPORTS; k++) begin
            scan_sum = {1'b0, scan_start} + (IDXW+1)'(k);
            if (scan_sum >= (IDXW+1)'(NPORTS)) begin
                scan_sum = scan_sum - (IDXW+1)'(NPORTS);
            end
            scan_idx = scan_sum[IDXW-1:0];
            if (!win_valid && bus.req[scan_idx]) begin
                win_valid = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state for value, status pulses and round-robin pointer.
    // ------------------------------------------------------------------
    always_comb begin
        value_d    = value_q;
        grant_d    = '0;
        wrapped_d  = 1'b0;
        ptr_d      = ptr_q;
        win_op     = bus.op[2*int'(win_idx) +: 2];
        win_data   = bus.wrdata[WIDTH*int'(win_idx) +: WIDTH];
        inc_full   = {1'b0, value_q} + (WIDTH+1)'(1);
        dec_full   = {1'b0, value_q} - (WIDTH+1)'(1);

        // Two or more bits set <=> clearing the lowest set bit leaves some.
        conflict_d = |(bus.req & (bus.req - NPORTS'(1)));

        if (win_valid) begin
            grant_d[win_idx] = 1'b1;

            case (win_op)
                OP_LOAD:  value_d = win_data;
                OP_CLEAR: value_d = '0;
                OP_INC: begin
                    if (inc_full[WIDTH]) begin
                        wrapped_d = 1'b1;
                        value_d   = (SATURATE != 0) ? MAX_VAL : inc_full[WIDTH-1:0];
                    end else begin
                        value_d   = inc_full[WIDTH-1:0];
                    end
                end
                default: begin
                    // OP_DEC: borrow out of the top bit means value was 0
                    if (dec_full[WIDTH]) begin
                        wrapped_d = 1'b1;
                        value_d   = (SATURATE != 0) ? '0 : dec_full[WIDTH-1:0];
                    end else begin
                        value_d   = dec_full[WIDTH-1:0];
                    end
                end
            endcase

            if (ARB_MODE != 0) begin
                ptr_d = (win_idx == IDXW'(NPORTS-1)) ? '0 : win_idx + IDXW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q    <= '0;
            grant_q    <= '0;
            wrapped_q  <= 1'b0;
            conflict_q <= 1'b0;
            ptr_q      <= '0;
        end else begin
            value_q    <= value_d;
            grant_q    <= grant_d;
            wrapped_q  <= wrapped_d;
            conflict_q <= conflict_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.value    = value_q;
    assign bus.grant    = grant_q;
    assign bus.wrapped  = wrapped_q;
    assign bus.conflict = conflict_q;
    assign bus.is_zero  = (value_q == '0);

endmodule

// File: tb/tb_shared_counter_arb.sv
// tb/tb_shared_counter_arb.sv - self-checking bench for shared_counter_arb
//
// Four WIDTH=9, NPORTS=4 instances share one stimulus stream:
//   inst 0: fixed priority, wrap      inst 1: fixed priority, saturate
//   inst 2: round-robin,    wrap      inst 3: round-robin,    saturate
module tb_shared_counter_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req_d;
    logic [7:0]  op_d;
    logic [35:0] wd_d;

    logic [8:0]  val_o  [4];
    logic [3:0]  gnt_o  [4];
    logic        wr_o   [4];
    logic        conf_o [4];
    logic        z_o    [4];

    // Reference model state, one per instance
    logic [8:0]  m_val  [4];
    logic [3:0]  m_gnt  [4];
    logic        m_wr   [4];
    logic        m_conf [4];
    int          m_ptr  [4];

    int n_vec;
    int n_miss;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gi
        shared_counter_arb_if #(.WIDTH(9), .NPORTS(4)) bus ();
        assign bus.req    = req_d;
        assign bus.op     = op_d;
        assign bus.wrdata = wd_d;
        shared_counter_arb #(
            .WIDTH(9), .NPORTS(4), .ARB_MODE(g / 2), .SATURATE(g % 2)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign val_o[g]  = bus.value;
        assign gnt_o[g]  = bus.grant;
        assign wr_o[g]   = bus.wrapped;
        assign conf_o[g] = bus.conflict;
        assign z_o[g]    = bus.is_zero;
    end

    // Applies one edge of stimulus to all instances, advances the model
    // from the rules (lowest-index or rotating winner, modular/clamped
    // arithmetic), and returns #1 after the edge so outputs are settled.
    task automatic drive(input logic r, input logic [3:0] rq,
                         input logic [7:0] o, input logic [35:0] wd);
        int         w;
        int         idx;
        bit         rr;
        bit         sat;
        logic [1:0] opc;
        logic [8:0] dat;
        rst   = r;
        req_d = rq;
        op_d  = o;
        wd_d  = wd;
        for (int g = 0; g < 4; g++) begin
            rr  = (g >= 2);
            sat = (g % 2) == 1;
            if (r) begin
                m_val[g] = 0; m_gnt[g] = 0; m_wr[g] = 0; m_conf[g] = 0; m_ptr[g] = 0;
            end else begin
                m_conf[g] = ($countones(rq) >= 2);
                m_gnt[g]  = 4'b0000;
                m_wr[g]   = 1'b0;
                if (rq != 4'b0000) begin
                    w = -1;
                    for (int k = 0; k < 4; k++) begin
                        idx = ((rr ? m_ptr[g] : 0) + k) % 4;
                        if (w < 0 && rq[idx]) w = idx;
                    end
                    m_gnt[g][w] = 1'b1;
                    opc = o[2*w +: 2];
                    dat = wd[9*w +: 9];
                    case (opc)
                        2'b00: m_val[g] = dat;
                        2'b11: m_val[g] = 9'd0;
                        2'b01: begin
                            if (m_val[g] == 9'd511) begin
                                m_wr[g]  = 1'b1;
                                m_val[g] = sat ? 9'd511 : 9'd0;
                            end else m_val[g] = m_val[g] + 9'd1;
                        end
                        default: begin
                            if (m_val[g] == 9'd0) begin
                                m_wr[g]  = 1'b1;
                                m_val[g] = sat ? 9'd0 : 9'd511;
                            end else m_val[g] = m_val[g] - 9'd1;
                        end
                    endcase
                    if (rr) m_ptr[g] = (w + 1) % 4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int n = 0; n < 6; n++) begin
            drive(1'b0, 4'($urandom), 8'($urandom), {4'($urandom), 32'($urandom)});
        end
        drive(1'b1, 4'($urandom), 8'($urandom), {4'($urandom), 32'($urandom)});
        drive(1'b1, 4'($urandom), 8'($urandom), {4'($urandom), 32'($urandom)});
        drive(1'b0, 4'b0000, 8'h00, 36'h0);
        for (int g = 0; g < 4; g++) begin
            n_vec++;
            if (val_o[g] !== 9'd0 || gnt_o[g] !== 4'b0000 || wr_o[g] !== 1'b0 ||
                conf_o[g] !== 1'b0 || z_o[g] !== 1'b1) begin
                n_miss++;
                $display("FAIL reset inst%0d: got val=%h gnt=%b wr=%b conf=%b z=%b want 000/0000/0/0/1",
                         g, val_o[g], gnt_o[g], wr_o[g], conf_o[g], z_o[g]);
            end
        end
    endtask

    task automatic test_load_inc_dec();
        logic [8:0] exp_v [5];
        logic [1:0] ops   [5];
        exp_v = '{9'h1F0, 9'h1F1, 9'h1F2, 9'h1F3, 9'h1F2};
        ops   = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
        for (int s = 0; s < 5; s++) begin
            drive(1'b0, 4'b0001, {6'b0, ops[s]}, {27'h0, 9'h1F0});
            for (int g = 0; g < 4; g++) begin
                n_vec++;
                if (val_o[g] !== exp_v[s] || gnt_o[g] !== 4'b0001 ||
                    wr_o[g] !== 1'b0 || conf_o[g] !== 1'b0) begin
                    n_miss++;
                    $display("FAIL load_inc_dec inst%0d step%0d: got val=%h gnt=%b wr=%b conf=%b want %h/0001/0/0",
                             g, s, val_o[g], gnt_o[g], wr_o[g], conf_o[g], exp_v[s]);
                end
            end
        end
    endtask

    task automatic test_wrap_sat();
        logic [8:0] want;
        logic       want_wr;
        drive(1'b0, 4'b0001, 8'h00, {27'h0, 9'h1FF});
        drive(1'b0, 4'b0001, 8'h01, 36'h0);
        for (int g = 0; g < 4; g++) begin
            want = (g % 2 == 1) ? 9'h1FF : 9'h000;
            n_vec++;
            if (val_o[g] !== want || wr_o[g] !== 1'b1) begin
                n_miss++;
                $display("FAIL wrap_inc inst%0d: got val=%h wr=%b want %h/1", g, val_o[g], wr_o[g], want);
            end
        end
        drive(1'b0, 4'b0001, 8'h02, 36'h0);
        for (int g = 0; g < 4; g++) begin
            want    = (g % 2 == 1) ? 9'h1FE : 9'h1FF;
            want_wr = (g % 2 == 0);
            n_vec++;
            if (val_o[g] !== want || wr_o[g] !== want_wr) begin
                n_miss++;
                $display("FAIL wrap_dec inst%0d: got val=%h wr=%b want %h/%b", g, val_o[g], wr_o[g], want, want_wr);
            end
        end
        drive(1'b0, 4'b0001, 8'h00, 36'h0);
        drive(1'b0, 4'b0001, 8'h02, 36'h0);
        for (int g = 0; g < 4; g++) begin
            want = (g % 2 == 1) ? 9'h000 : 9'h1FF;
            n_vec++;
            if (val_o[g] !== want || wr_o[g] !== 1'b1) begin
                n_miss++;
                $display("FAIL dec_at_zero inst%0d: got val=%h wr=%b want %h/1", g, val_o[g], wr_o[g], want);
            end
        end
        drive(1'b0, 4'b0000, 8'h00, 36'h0);
        for (int g = 0; g < 4; g++) begin
            n_vec++;
            if (wr_o[g] !== 1'b0 || gnt_o[g] !== 4'b0000) begin
                n_miss++;
                $display("FAIL wrap_pulse inst%0d: got wr=%b gnt=%b want 0/0000", g, wr_o[g], gnt_o[g]);
            end
        end
    endtask

    task automatic test_fixed_priority();
        logic [3:0] want_g;
        drive(1'b0, 4'b0001, 8'h00, {27'h0, 9'd5});
        for (int s = 0; s < 3; s++) begin
            drive(1'b0, 4'b1110, 8'b01010101, 36'h0);
            for (int g = 0; g < 4; g++) begin
                // Round-robin pointer sits at 1 after the port-0 load and then rotates
                want_g = (g < 2) ? 4'b0010 : (4'b0010 << s);
                n_vec++;
                if (val_o[g] !== 9'(6 + s) || gnt_o[g] !== want_g || conf_o[g] !== 1'b1) begin
                    n_miss++;
                    $display("FAIL priority inst%0d step%0d: got val=%h gnt=%b conf=%b want %h/%b/1",
                             g, s, val_o[g], gnt_o[g], conf_o[g], 9'(6 + s), want_g);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] want_g;
        logic [8:0] want_v;
        drive(1'b1, 4'b0000, 8'h00, 36'h0);
        for (int s = 0; s < 8; s++) begin
            drive(1'b0, 4'b1111, 8'h00, {9'd13, 9'd12, 9'd11, 9'd10});
            for (int g = 0; g < 4; g++) begin
                want_g = (g >= 2) ? (4'b0001 << (s % 4)) : 4'b0001;
                want_v = (g >= 2) ? 9'(10 + s % 4) : 9'd10;
                n_vec++;
                if (gnt_o[g] !== want_g || val_o[g] !== want_v || conf_o[g] !== 1'b1) begin
                    n_miss++;
                    $display("FAIL round_robin inst%0d step%0d: got gnt=%b val=%h conf=%b want %b/%h/1",
                             g, s, gnt_o[g], val_o[g], conf_o[g], want_g, want_v);
                end
            end
        end
    endtask

    task automatic test_rr_hold();
        logic [3:0] want_g;
        drive(1'b1, 4'b0000, 8'h00, 36'h0);
        drive(1'b0, 4'b0100, 8'h00, {9'h0, 9'h033, 9'h0, 9'h0});
        for (int s = 0; s < 3; s++) begin
            drive(1'b0, 4'b0000, 8'h00, 36'h0);
            for (int g = 0; g < 4; g++) begin
                n_vec++;
                if (gnt_o[g] !== 4'b0000 || val_o[g] !== 9'h033) begin
                    n_miss++;
                    $display("FAIL idle_hold inst%0d: got gnt=%b val=%h want 0000/033", g, gnt_o[g], val_o[g]);
                end
            end
        end
        drive(1'b0, 4'b1011, 8'h55, 36'h0);
        for (int g = 0; g < 4; g++) begin
            want_g = (g >= 2) ? 4'b1000 : 4'b0001;
            n_vec++;
            if (gnt_o[g] !== want_g || val_o[g] !== 9'h034) begin
                n_miss++;
                $display("FAIL rr_ptr_hold inst%0d: got gnt=%b val=%h want %b/034", g, gnt_o[g], val_o[g], want_g);
            end
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b0, 4'b0001, 8'h00, {27'h0, 9'h077});
        drive(1'b1, 4'b0001, 8'h00, {27'h0, 9'h0AA});
        for (int g = 0; g < 4; g++) begin
            n_vec++;
            if (val_o[g] !== 9'd0 || gnt_o[g] !== 4'b0000 || wr_o[g] !== 1'b0 || conf_o[g] !== 1'b0) begin
                n_miss++;
                $display("FAIL mid_reset inst%0d: got val=%h gnt=%b wr=%b conf=%b want 000/0000/0/0",
                         g, val_o[g], gnt_o[g], wr_o[g], conf_o[g]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 19) == 0), 4'($urandom), 8'($urandom),
                  {4'($urandom), 32'($urandom)});
            for (int g = 0; g < 4; g++) begin
                n_vec++;
                if (val_o[g] !== m_val[g] || gnt_o[g] !== m_gnt[g] || wr_o[g] !== m_wr[g] ||
                    conf_o[g] !== m_conf[g] || z_o[g] !== (m_val[g] == 9'd0)) begin
                    n_miss++;
                    $display("FAIL random inst%0d cyc%0d: got val=%h gnt=%b wr=%b conf=%b z=%b want %h/%b/%b/%b/%b",
                             g, n, val_o[g], gnt_o[g], wr_o[g], conf_o[g], z_o[g],
                             m_val[g], m_gnt[g], m_wr[g], m_conf[g], (m_val[g] == 9'd0));
                end
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        req_d  = '0;
        op_d   = '0;
        wd_d   = '0;
        for (int g = 0; g < 4; g++) begin
            m_val[g] = 0; m_gnt[g] = 0; m_wr[g] = 0; m_conf[g] = 0; m_ptr[g] = 0;
        end
        @(negedge clk);
        drive(1'b1, 4'b0000, 8'h00, 36'h0);
        test_reset();
        test_load_inc_dec();
        test_wrap_sat();
        test_fixed_priority();
        test_round_robin();
        test_rr_hold();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/shared_counter_arb.md
Name: shared_counter_arb

Overview:
- Parametrised multi-port shared counter/register for the datapath.
- NPORTS requesters may each load, increment, decrement or clear one WIDTH-bit value.
- An internal arbiter (fixed-priority or round-robin) serialises simultaneous requests, so no out-of-band write protocol is needed and data is never OR-merged.
- Registered grant, wrap and conflict outputs let requesters confirm their operation was applied.

Parameters:
- WIDTH, 9: counter/data width in bits (>=2).
- NPORTS, 2: number of requester ports (2..8).
- ARB_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- SATURATE, 0: 0 = inc/dec wrap modulo 2^WIDTH; 1 = inc/dec clamp at max/0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active high.
- req  in  NPORTS  per-port request, sampled at each rising edge.
- op  in  2*NPORTS  per-port opcode; port i uses op[2i+1:2i]. 00 load, 01 inc, 10 dec, 11 clear.
- wrdata  in  WIDTH*NPORTS  per-port load data; port i uses wrdata[WIDTH*i +: WIDTH].
- value  out  WIDTH  current counter value (register).
- grant  out  NPORTS  registered one-hot; bit i high for the one cycle after port i's op was applied.
- wrapped  out  1  registered pulse; the applied inc/dec wrapped (SATURATE=0) or was clamped (SATURATE=1).
- conflict  out  1  registered pulse; more than one req bit was high at the edge.
- is_zero  out  1  combinational, high when value == 0.

Behaviour:
- Reset: rst high at an edge sets value=0, grant=0, wrapped=0, conflict=0 and RR pointer=0. Requests at that edge are discarded. Reset applies mid-operation with no partial effects.
- Each edge with req != 0 selects exactly one winner w. op[w] is applied to value at that same edge (latency 1: the new value is visible the cycle after req is sampled).
- The same edge sets grant to one-hot(w). With req == 0, value holds and grant=0.
- Losers are not queued. A requester keeps req high until it sees its grant bit, then drops req before the next edge, or keeps it high to issue another op. Holding req high through a grant cycle causes a further op.
- Fixed priority (ARB_MODE=0): w is the lowest index with req set.
- Round-robin (ARB_MODE=1):
  - Pointer p names the highest-priority port; search runs p, p+1, ..., wrapping modulo NPORTS.
  - After a grant to w, p <= (w+1) mod NPORTS. p holds when there is no request.
- Operations:
  - load: value <= wrdata[w].
  - clear: value <= 0.
  - inc: value+1. At 2^WIDTH-1: result 0 if SATURATE=0, else hold at 2^WIDTH-1. wrapped=1 in either case.
  - dec: value-1. At 0: result 2^WIDTH-1 if SATURATE=0, else hold at 0. wrapped=1 in either case.
- wrapped is 0 for load/clear and for non-boundary inc/dec.
- conflict=1 when popcount(req) >= 2 at an edge, else 0. It is independent of grant.
- All outputs except is_zero come from registers. No combinational path from req/op/wrdata to any output.
- Arithmetic is strictly WIDTH bits; any carry/borrow is used only to generate wrapped.

Test Plan:
- Reset/idle: rst=1 for 2 cycles after random ops, then idle -> value=0, grant=0, wrapped=0, conflict=0, is_zero=1.
- Load/inc/dec (WIDTH=9), single port 0:
  - load 0x1F0, then inc x3 -> value 0x1F0, 0x1F1, 0x1F2, 0x1F3 on successive cycles; grant=01 each cycle.
  - then dec -> 0x1F2.
- Wrap vs saturate:
  - SATURATE=0: load 0x1FF, inc -> value=0x000, wrapped=1; then dec -> 0x1FF, wrapped=1.
  - SATURATE=1: same stimulus -> value stays 0x1FF with wrapped=1; load 0, dec -> value stays 0, wrapped=1.
- Fixed priority, NPORTS=4: req=1110, ops all inc from 5, held 3 cycles -> port 1 wins each cycle, value 6, 7, 8; grant=0010; conflict=1 each cycle.
- Round-robin, NPORTS=4: req=1111 held 8 cycles, each port loading its index+10 -> grant order 0,1,2,3,0,1,2,3; value 10,11,12,13,10,...
- Round-robin pointer hold: grant to port 2, idle 3 cycles, then req=1011 -> port 3 wins.
- Mid-operation reset: rst=1 in the same cycle as req=01 load 0x0AA -> value=0, grant=0; load ignored.
